pll_lock_supervisor: RTL
========================

Name: pll_lock_supervisor

Overview:
Sequences the rPLL that generates the SPI7001 clocks. It drives the PLL reset, waits for LOCK and qualifies it as stable before releasing downstream logic. It retries on lock timeout and re-sequences on lock loss or on software request. It runs on the free-running reference clock that also feeds the PLL CLKIN, and its outputs gate the SPI7001 driver reset.

Parameters:
RST_CYCLES, 16, width of the PLL reset pulse in clk cycles (>=1)
LOCK_STABLE_CYCLES, 1024, consecutive synchronised-lock cycles required before RUN
LOCK_TIMEOUT_CYCLES, 65536, cycles allowed in WAIT_LOCK before a retry
MAX_RETRIES, 4, timeouts tolerated before FAULT (0..7)
CNT_W, 17, cycle-counter width; must hold the largest of the three cycle parameters

Ports:
clk  in  1  free-running reference clock (same source as PLL CLKIN)
rst  in  1  asynchronous reset, active-high
pll_lock_i  in  1  PLL LOCK, asynchronous to clk
relock_req_i  in  1  single-cycle request to re-sequence the PLL
pll_rst_o  out  1  drives PLL RESET
clk_ready_o  out  1  PLL clocks valid
downstream_rst_o  out  1  reset for logic clocked by the PLL outputs
fault_o  out  1  PLL failed to lock after MAX_RETRIES
retry_cnt_o  out  3  timeouts since the last successful lock
state_o  out  3  current state: RESET_PLL=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAULT=4

Behaviour:
- All outputs are registered.
- Reset values: state RESET_PLL, pll_rst_o=1, clk_ready_o=0, downstream_rst_o=1, fault_o=0, retry_cnt_o=0, cycle counter=0, lock synchroniser flops=0.
- Lock synchroniser: pll_lock_i passes through a 2-FF synchroniser to give lock_s. All decisions use lock_s only.
- Counter: the cycle counter clears on every state change.
- RESET_PLL:
  - pll_rst_o=1.
  - Stays for exactly RST_CYCLES cycles, then goes to WAIT_LOCK.
  - pll_rst_o drops on the same edge that state_o becomes 1.
- WAIT_LOCK:
  - lock_s=1 -> STABLE.
  - Counter reaches LOCK_TIMEOUT_CYCLES-1 with lock_s=0:
    - retry_cnt < MAX_RETRIES -> retry_cnt+1, go to RESET_PLL.
    - otherwise -> FAULT.
  - If lock_s=1 arrives on the timeout cycle, lock wins.
- STABLE:
  - Counts consecutive lock_s=1 cycles.
  - lock_s=0 -> WAIT_LOCK, counter restarts. retry_cnt is not incremented (a glitch is not a timeout).
  - Counter reaches LOCK_STABLE_CYCLES-1 with lock_s=1 -> RUN.
- RUN:
  - On entry: clk_ready_o=1, downstream_rst_o=0, retry_cnt cleared.
  - lock_s=0 -> RESET_PLL, with clk_ready_o=0 and downstream_rst_o=1 on that same edge.
- FAULT:
  - pll_rst_o=1, fault_o=1, clk_ready_o=0, downstream_rst_o=1.
  - Only rst or relock_req_i leaves FAULT.
- relock_req_i:
  - Highest priority, in every state.
  - Next state RESET_PLL, retry_cnt=0, fault_o=0, counter=0.
  - In RUN it also drops clk_ready_o and asserts downstream_rst_o on the same edge.
  - A request during RESET_PLL restarts the full RST_CYCLES pulse.
- Latency: pll_lock_i rising (stable) -> STABLE is entered 3 edges later.
- downstream_rst_o is deasserted only while in RUN.
- Reset mid-operation: rst asserted in any state returns all outputs to their reset values asynchronously.

Optional Feature:
LOCK_LOSS_COUNTER_EN.
- Defined: adds output port lock_loss_cnt_o (16 bits). It increments by 1 on every RUN -> RESET_PLL transition caused by lock_s=0, and saturates at 0xFFFF. It is not incremented by relock_req_i and is cleared only by rst.
- Undefined: the port and the counter are absent, and all other behaviour is identical.

Test Plan:
All scenarios use RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=2.
1. Normal bring-up: release rst, raise pll_lock_i 10 cycles after pll_rst_o falls -> pll_rst_o high exactly 4 cycles; state 1->2 three edges after lock rises; state 3 with clk_ready_o=1, downstream_rst_o=0 eight cycles later.
2. Lock glitch in STABLE: drop pll_lock_i for 1 cycle after 5 stable cycles -> state returns to 1 with retry_cnt_o=0; after lock returns, a full 8 cycles is needed to reach RUN.
3. Timeout and FAULT: hold pll_lock_i=0 -> three RESET_PLL pulses; retry_cnt_o goes 0,1,2; then state 4 with fault_o=1 and pll_rst_o=1; a relock_req_i pulse -> state 0, fault_o=0, retry_cnt_o=0.
4. Lock loss in RUN: drop pll_lock_i -> clk_ready_o=0 and downstream_rst_o=1 three edges later, state 0, a new 4-cycle reset pulse. With LOCK_LOSS_COUNTER_EN, lock_loss_cnt_o goes 0->1.
5. Simultaneous events: relock_req_i on the same cycle as a WAIT_LOCK timeout with retry_cnt=1 -> state 0, retry_cnt_o=0 (request wins over retry increment).
6. Async reset mid-STABLE: assert rst between edges -> outputs return to reset values immediately without waiting for a clk edge.

Source files
------------

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: sequences the rPLL reset, qualifies LOCK and gates the downstream reset.
// Optional macro LOCK_LOSS_COUNTER_EN adds a saturating 16-bit lock-loss counter output.
module pll_lock_supervisor #(
    parameter int unsigned RST_CYCLES          = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
    parameter int unsigned MAX_RETRIES         = 4,
    parameter int unsigned CNT_W               = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pll_lock_i,
    input  logic        relock_req_i,
    output logic        pll_rst_o,
    output logic        clk_ready_o,
    output logic        downstream_rst_o,
    output logic        fault_o,
    output logic [2:0]  retry_cnt_o,
`ifdef LOCK_LOSS_COUNTER_EN
    output logic [15:0] lock_loss_cnt_o,
`endif
    output logic [2:0]  state_o
);

    localparam logic [2:0] S_RESET_PLL = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK = 3'd1;
    localparam logic [2:0] S_STABLE    = 3'd2;
    localparam logic [2:0] S_RUN       = 3'd3;
    localparam logic [2:0] S_FAULT     = 3'd4;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [2:0]       RETRY_MAX    = 3'(MAX_RETRIES);

    logic             lock_meta;
    logic             lock_s;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [2:0]       state_nxt;
    logic [2:0]       retry_nxt;
    logic             lock_lost;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_lock_i;
            lock_s    <= lock_meta;
        end
    end

    always_comb begin
        state_nxt = state_o;
        retry_nxt = retry_cnt_o;
        cnt_nxt   = cnt;
        lock_lost = 1'b0;
        if (relock_req_i) begin
            state_nxt = S_RESET_PLL;
            retry_nxt = '0;
        end else begin
            case (state_o)
                S_RESET_PLL: begin
                    cnt_nxt = cnt + 1'b1;
                    if (cnt == RST_LAST) state_nxt = S_WAIT_LOCK;
                end
                S_WAIT_LOCK: begin
                    cnt_nxt = cnt + 1'b1;
                    if (lock_s) begin
                        state_nxt = S_STABLE;
                    end else if (cnt == TIMEOUT_LAST) begin
                        if (retry_cnt_o < RETRY_MAX) begin
                            retry_nxt = retry_cnt_o + 3'd1;
                            state_nxt = S_RESET_PLL;
                        end else begin
                            state_nxt = S_FAULT;
                        end
                    end
                end
                S_STABLE: begin
                    cnt_nxt = cnt + 1'b1;
                    if (!lock_s) begin
                        state_nxt = S_WAIT_LOCK;
                    end else if (cnt == STABLE_LAST) begin
                        state_nxt = S_RUN;
                        retry_nxt = '0;
                    end
                end
                S_RUN: begin
                    if (!lock_s) begin
                        state_nxt = S_RESET_PLL;
                        lock_lost = 1'b1;
                    end
                end
                S_FAULT: ;
                default: state_nxt = S_RESET_PLL;
            endcase
        end
        // A request in RESET_PLL does not change state but must still restart the pulse.
        if (relock_req_i || (state_nxt != state_o)) cnt_nxt = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_o          <= S_RESET_PLL;
            cnt              <= '0;
            retry_cnt_o      <= '0;
            pll_rst_o        <= 1'b1;
            clk_ready_o      <= 1'b0;
            downstream_rst_o <= 1'b1;
            fault_o          <= 1'b0;
        end else begin
            state_o          <= state_nxt;
            cnt              <= cnt_nxt;
            retry_cnt_o      <= retry_nxt;
            pll_rst_o        <= (state_nxt == S_RESET_PLL) || (state_nxt == S_FAULT);
            clk_ready_o      <= (state_nxt == S_RUN);
            downstream_rst_o <= (state_nxt != S_RUN);
            fault_o          <= (state_nxt == S_FAULT);
        end
    end

`ifdef LOCK_LOSS_COUNTER_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_loss_cnt_o <= '0;
        end else if (lock_lost && (lock_loss_cnt_o != 16'hFFFF)) begin
            lock_loss_cnt_o <= lock_loss_cnt_o + 16'd1;
        end
    end
`else
    logic unused_lock_lost;
    assign unused_lock_lost = lock_lost;
`endif

endmodule
